// File: rtl/txt_console_ctrl.sv
// txt_console_ctrl: text-console write engine (cursor, backspace, newline, scroll, clear)
// Optional TXT_LINE_END_EN: per-row line_end file used as the backspace-at-col-0 target
module txt_console_ctrl #(
   parameter int COLS      = 70,
   parameter int ROWS      = 30,
   parameter int COL_W     = 7,
   parameter int ROW_W     = 5,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [7:0]             in_ascii,
   output logic                   in_ready,
   output logic                   ram_we,
   output logic [COL_W+ROW_W-1:0] ram_waddr,
   output logic [7:0]             ram_wdata,
   output logic [COL_W+ROW_W-1:0] cursor_addr,
   output logic [ROW_W-1:0]       scroll_base,
   output logic                   cursor_on
);
   localparam logic [COL_W-1:0] LC = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] LR = ROW_W'(ROWS - 1);
   localparam int BW = $clog2(BLINK_DIV + 1);
   typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;
   state_t state, state_n;
   logic [COL_W-1:0] cur_col, cur_col_n, clr_col, clr_col_n, bs_tgt, le_val;
   logic [ROW_W-1:0] cur_row, cur_row_n, clr_row, clr_row_n, sb_n, phys, phys_up, le_idx;
   logic [COL_W+ROW_W-1:0] waddr_n;
   logic [7:0] wdata_n;
   logic [BW-1:0] blink_cnt;
   logic we_n, le_we, nl, xfer;

   function automatic logic [ROW_W-1:0] wrap_add(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
      logic [ROW_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s >= (ROW_W+1)'(ROWS) ? ROW_W'(s - (ROW_W+1)'(ROWS)) : s[ROW_W-1:0];
   endfunction

   assign phys        = wrap_add(scroll_base, cur_row);
   assign phys_up     = wrap_add(scroll_base, cur_row - 1'b1);
   assign in_ready    = state == IDLE;
   assign xfer        = in_valid & in_ready;
   assign cursor_addr = {cur_col, phys};

`ifdef TXT_LINE_END_EN
   logic [COL_W-1:0] line_end [ROWS];
   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int i = 0; i < ROWS; i++) line_end[i] <= '0;
      else if (state == CLEAR_ALL)
         for (int i = 0; i < ROWS; i++) line_end[i] <= '0;
      else if (le_we)
         line_end[le_idx] <= le_val;
   assign bs_tgt = line_end[phys_up];
`else
   logic unused_le;
   assign unused_le = ^{le_we, le_idx, le_val};
   assign bs_tgt = LC;
`endif

   always_comb begin
      state_n   = state;
      cur_col_n = cur_col;
      cur_row_n = cur_row;
      sb_n      = scroll_base;
      clr_col_n = clr_col;
      clr_row_n = clr_row;
      we_n      = 1'b0;
      waddr_n   = {cur_col, phys};
      wdata_n   = 8'h20;
      le_we     = 1'b0;
      le_idx    = phys;
      le_val    = cur_col;
      nl        = 1'b0;
      case (state)
         CLEAR_ALL: begin
            we_n      = 1'b1;
            waddr_n   = {clr_col, clr_row};
            clr_col_n = clr_col == LC ? '0 : clr_col + 1'b1;
            clr_row_n = clr_col != LC ? clr_row : clr_row == LR ? '0 : clr_row + 1'b1;
            state_n   = clr_col == LC && clr_row == LR ? IDLE : CLEAR_ALL;
         end
         CLEAR_ROW: begin
            we_n      = 1'b1;
            waddr_n   = {clr_col, clr_row};
            le_we     = 1'b1;
            le_idx    = clr_row;
            le_val    = '0;
            clr_col_n = clr_col == LC ? '0 : clr_col + 1'b1;
            state_n   = clr_col == LC ? IDLE : CLEAR_ROW;
         end
         default: if (xfer) begin
            if (in_ascii >= 8'h20 && in_ascii <= 8'h7E) begin
               we_n    = 1'b1;
               wdata_n = in_ascii;
               le_we   = cur_col == LC;
               nl      = cur_col == LC;
               cur_col_n = cur_col + 1'b1;
            end else if (in_ascii == 8'h0D || in_ascii == 8'h0A) begin
               le_we = 1'b1;
               nl    = 1'b1;
            end else if (in_ascii == 8'h08) begin
               if (cur_col != '0) begin
                  cur_col_n = cur_col - 1'b1;
                  we_n      = 1'b1;
                  waddr_n   = {cur_col - 1'b1, phys};
               end else if (cur_row != '0) begin
                  cur_row_n = cur_row - 1'b1;
                  cur_col_n = bs_tgt;
                  we_n      = 1'b1;
                  waddr_n   = {bs_tgt, phys_up};
               end
            end else if (in_ascii == 8'h0C) begin
               state_n   = CLEAR_ALL;
               cur_col_n = '0;
               cur_row_n = '0;
               sb_n      = '0;
               clr_col_n = '0;
               clr_row_n = '0;
            end
            // the old top physical row becomes the new bottom line and must be blanked
            if (nl) begin
               cur_col_n = '0;
               cur_row_n = cur_row == LR ? LR : cur_row + 1'b1;
               if (cur_row == LR) begin
                  sb_n      = wrap_add(scroll_base, ROW_W'(1));
                  state_n   = CLEAR_ROW;
                  clr_col_n = '0;
                  clr_row_n = scroll_base;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= CLEAR_ALL;
         cur_col     <= '0;
         cur_row     <= '0;
         scroll_base <= '0;
         clr_col     <= '0;
         clr_row     <= '0;
         ram_we      <= 1'b0;
         ram_waddr   <= '0;
         ram_wdata   <= 8'h20;
      end else begin
         state       <= state_n;
         cur_col     <= cur_col_n;
         cur_row     <= cur_row_n;
         scroll_base <= sb_n;
         clr_col     <= clr_col_n;
         clr_row     <= clr_row_n;
         ram_we      <= we_n;
         ram_waddr   <= waddr_n;
         ram_wdata   <= wdata_n;
      end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         blink_cnt <= '0;
         cursor_on <= 1'b1;
      end else if (xfer) begin
         blink_cnt <= '0;
         cursor_on <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         cursor_on <= ~cursor_on;
      end else
         blink_cnt <= blink_cnt + 1'b1;
endmodule

// File: tb/tb_txt_console_ctrl.sv
// tb_txt_console_ctrl: directed table, hand sequences and random traffic against a queue-based screen model
module tb_txt_console_ctrl;
   localparam int COLS = 8, ROWS = 4, CW = 3, RW = 2, BD = 16;
`ifdef TXT_LINE_END_EN
   localparam bit LE = 1'b1;
`else
   localparam bit LE = 1'b0;
`endif

   logic clk = 0, reset = 0, in_valid = 0;
   logic [7:0] in_ascii = 0;
   logic in_ready, ram_we, cursor_on;
   logic [CW+RW-1:0] ram_waddr, cursor_addr;
   logic [7:0] ram_wdata;
   logic [RW-1:0] scroll_base;

   txt_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .COL_W(CW), .ROW_W(RW), .BLINK_DIV(BD)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ascii(in_ascii), .in_ready(in_ready),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .cursor_addr(cursor_addr),
      .scroll_base(scroll_base), .cursor_on(cursor_on));

   always #5 clk = ~clk;

   int passed = 0, total = 0;
   int clrq[$];
   int le[ROWS];
   int m_col, m_row, m_sb, since, e_addr, e_data;
   bit m_ready, e_we;

   typedef struct { logic [7:0] a; bit we; int addr; int data; int cur; } vec_t;
   vec_t tbl[13];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic int phys(input int r);
      return (m_sb + r) % ROWS;
   endfunction

   function automatic int addr_of(input int c, input int r);
      return c * (1 << RW) + r;
   endfunction

   task automatic model_init();
      clrq.delete();
      for (int i = 0; i < ROWS * COLS; i++) clrq.push_back(addr_of(i % COLS, i / COLS));
      for (int i = 0; i < ROWS; i++) le[i] = 0;
      m_col = 0; m_row = 0; m_sb = 0; since = 0; m_ready = 0; e_we = 0;
   endtask

   task automatic wr(input int c, input int r, input int d);
      e_we = 1; e_addr = addr_of(c, r); e_data = d;
   endtask

   task automatic m_newline();
      if (m_row < ROWS - 1) m_row++;
      else begin
         for (int c = 0; c < COLS; c++) clrq.push_back(addr_of(c, m_sb));
         le[m_sb] = 0;
         m_sb = (m_sb + 1) % ROWS;
      end
   endtask

   task automatic apply(input logic [7:0] c);
      int p;
      p = phys(m_row);
      if (c >= 8'h20 && c <= 8'h7E) begin
         wr(m_col, p, int'(c));
         if (m_col == COLS - 1) begin le[p] = COLS - 1; m_col = 0; m_newline(); end
         else m_col++;
      end else if (c == 8'h0D || c == 8'h0A) begin
         le[p] = m_col; m_col = 0; m_newline();
      end else if (c == 8'h08) begin
         if (m_col > 0) begin m_col--; wr(m_col, p, 32); end
         else if (m_row > 0) begin
            m_row--; p = phys(m_row);
            m_col = LE ? le[p] : COLS - 1;
            wr(m_col, p, 32);
         end
      end else if (c == 8'h0C) begin
         model_init();
      end
   endtask

   task automatic model_edge(input bit x, input logic [7:0] c);
      e_we = 0;
      if (!x && clrq.size() > 0) begin e_we = 1; e_addr = clrq.pop_front(); e_data = 32; end
      if (x) apply(c);
      m_ready = clrq.size() == 0;
      since = x ? 0 : since + 1;
   endtask

   task automatic check_all();
      chk("in_ready", int'(in_ready), int'(m_ready));
      chk("ram_we", int'(ram_we), int'(e_we));
      if (e_we) begin
         chk("ram_waddr", int'(ram_waddr), e_addr);
         chk("ram_wdata", int'(ram_wdata), e_data);
      end
      chk("cursor_addr", int'(cursor_addr), addr_of(m_col, phys(m_row)));
      chk("scroll_base", int'(scroll_base), m_sb);
      chk("cursor_on", int'(cursor_on), int'(((since / BD) % 2) == 0));
   endtask

   task automatic tick();
      bit x;
      logic [7:0] c;
      x = in_valid && m_ready;
      c = in_ascii;
      @(posedge clk);
      model_edge(x, c);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      reset = 1; in_valid = 0;
      #2;
      chk("rst in_ready", int'(in_ready), 0);
      chk("rst ram_we", int'(ram_we), 0);
      chk("rst ram_waddr", int'(ram_waddr), 0);
      chk("rst ram_wdata", int'(ram_wdata), 32);
      chk("rst cursor_addr", int'(cursor_addr), 0);
      chk("rst scroll_base", int'(scroll_base), 0);
      chk("rst cursor_on", int'(cursor_on), 1);
      @(negedge clk); @(negedge clk);
      reset = 0;
      model_init();
   endtask

   task automatic wait_ready(input int row, output int n, output int nw, output int nr);
      n = 0; nw = 0; nr = 0;
      while (!in_ready && n < 200) begin
         tick(); n++;
         if (ram_we) begin nw++; if (int'(ram_waddr) % (1 << RW) == row) nr++; end
      end
   endtask

   function automatic logic [7:0] pick();
      int r;
      r = $urandom_range(99);
      if (r < 55) return 8'($urandom_range(8'h7E, 8'h20));
      if (r < 70) return r[0] ? 8'h0D : 8'h0A;
      if (r < 88) return 8'h08;
      if (r < 90) return 8'h0C;
      return 8'($urandom_range(255));
   endfunction

   initial begin
      int n, nw, nr;
      tbl[0]  = '{8'h41, 1, 0, 8'h41, 4};
      tbl[1]  = '{8'h42, 1, 4, 8'h42, 8};
      tbl[2]  = '{8'h0D, 0, 0, 0, 1};
      tbl[3]  = '{8'h58, 1, 1, 8'h58, 5};
      tbl[4]  = '{8'h59, 1, 5, 8'h59, 9};
      tbl[5]  = '{8'h0D, 0, 0, 0, 2};
      tbl[6]  = '{8'h08, 1, LE ? 9 : 29, 32, LE ? 9 : 29};
      tbl[7]  = '{8'h08, 1, LE ? 5 : 25, 32, LE ? 5 : 25};
      tbl[8]  = '{8'h00, 0, 0, 0, LE ? 5 : 25};
      tbl[9]  = '{8'h7F, 0, 0, 0, LE ? 5 : 25};
      tbl[10] = '{8'h0A, 0, 0, 0, 2};
      tbl[11] = '{8'h08, 1, LE ? 5 : 29, 32, LE ? 5 : 29};
      tbl[12] = '{8'h0D, 0, 0, 0, 2};
      #1;
      do_reset();
      wait_ready(0, n, nw, nr);
      chk("init clear cycles", n, 32);
      chk("init clear writes", nw, 32);

      in_valid = 1;
      foreach (tbl[i]) begin
         in_ascii = tbl[i].a;
         tick();
         chk($sformatf("tbl%0d ready", i), int'(in_ready), 1);
         chk($sformatf("tbl%0d we", i), int'(ram_we), int'(tbl[i].we));
         if (tbl[i].we) begin
            chk($sformatf("tbl%0d addr", i), int'(ram_waddr), tbl[i].addr);
            chk($sformatf("tbl%0d data", i), int'(ram_wdata), tbl[i].data);
         end
         chk($sformatf("tbl%0d cursor", i), int'(cursor_addr), tbl[i].cur);
      end

      in_ascii = 8'h0D;
      tick(); tick();
      in_valid = 0;
      chk("scroll sb", int'(scroll_base), 1);
      chk("scroll ready", int'(in_ready), 0);
      chk("scroll cursor", int'(cursor_addr), 0);
      wait_ready(0, n, nw, nr);
      chk("scroll busy cycles", n, 8);
      chk("scroll writes", nw, 8);
      chk("scroll row0 writes", nr, 8);

      in_valid = 1;
      for (int k = 0; k < 8; k++) begin in_ascii = 8'h61 + 8'(k); tick(); end
      in_valid = 0;
      chk("wrap we", int'(ram_we), 1);
      chk("wrap addr", int'(ram_waddr), 28);
      chk("wrap data", int'(ram_wdata), 8'h68);
      chk("wrap sb", int'(scroll_base), 2);
      chk("wrap ready", int'(in_ready), 0);
      tick();
      chk("wrap clr addr", int'(ram_waddr), 1);
      chk("wrap clr we", int'(ram_we), 1);
      wait_ready(1, n, nw, nr);
      chk("wrap clr cycles", n, 7);
      chk("wrap clr row1", nr, 7);

      in_valid = 1; in_ascii = 8'h08; tick(); in_valid = 0;
      chk("bs up addr", int'(ram_waddr), 28);
      chk("bs up data", int'(ram_wdata), 32);
      chk("bs up cursor", int'(cursor_addr), 28);

      in_valid = 1; in_ascii = 8'h0C; tick(); in_valid = 0;
      chk("ff we", int'(ram_we), 0);
      chk("ff sb", int'(scroll_base), 0);
      chk("ff cursor", int'(cursor_addr), 0);
      chk("ff ready", int'(in_ready), 0);
      repeat (10) tick();
      chk("ff clr10 addr", int'(ram_waddr), 5);
      do_reset();
      tick();
      chk("restart we", int'(ram_we), 1);
      chk("restart addr", int'(ram_waddr), 0);
      wait_ready(0, n, nw, nr);
      chk("restart rest", n, 31);

      in_valid = 1; in_ascii = 8'h08; tick(); in_valid = 0;
      chk("bs origin we", int'(ram_we), 0);
      chk("bs origin cursor", int'(cursor_addr), 0);
      chk("blink forced", int'(cursor_on), 1);
      repeat (BD - 1) tick();
      chk("blink before", int'(cursor_on), 1);
      tick();
      chk("blink off", int'(cursor_on), 0);
      repeat (BD) tick();
      chk("blink on", int'(cursor_on), 1);
      repeat (8) tick();
      in_valid = 1; in_ascii = 8'h00; tick(); in_valid = 0;
      chk("blink restart", int'(cursor_on), 1);
      repeat (BD - 1) tick();
      chk("blink hold", int'(cursor_on), 1);
      tick();
      chk("blink off2", int'(cursor_on), 0);

      for (int i = 0; i < 1500; i++) begin
         bit acc;
         if (!in_valid && $urandom_range(3) != 0) begin in_valid = 1; in_ascii = pick(); end
         acc = in_valid && m_ready;
         tick();
         if (acc) begin in_valid = 1'($urandom_range(1)); in_ascii = pick(); end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
